// File: rtl/irq_ctrl_if.sv
// Register bus and CP0 request/acknowledge/return handshake of the interrupt controller.
// The master side is the CPU/CP0 and the slave side is irq_ctrl.
interface irq_ctrl_if #(
    parameter int ID_W = 2
);
    logic            wr_en;
    logic [1:0]      wr_addr;
    logic [31:0]     wr_data;
    logic [1:0]      rd_addr;
    logic [31:0]     rd_data;
    logic            irq_ack;
    logic            irq_done;
    logic            irq;
    logic [ID_W-1:0] irq_id;
    logic            busy;

    modport master (
        output wr_en, wr_addr, wr_data, rd_addr, irq_ack, irq_done,
        input  rd_data, irq, irq_id, busy
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, rd_addr, irq_ack, irq_done,
        output rd_data, irq, irq_id, busy
    );
endinterface

// File: rtl/irq_ctrl.sv
// Interrupt request generator for the CP0 ir_in line: edge-latched sources plus a
// compare-match timer on source 0, fixed priority, one request in service at a time.
module irq_ctrl #(
    parameter int  ID_W    = 2,
    parameter int  TIMER_W = 32,
    localparam int N       = 2 ** ID_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] src_in,
    irq_ctrl_if.slave    bus
);
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_SERVICE} state_t;

    localparam logic [1:0] A_MASK = 2'd0;
    localparam logic [1:0] A_PEND = 2'd1;
    localparam logic [1:0] A_TCMP = 2'd2;
    localparam logic [1:0] A_TCNT = 2'd3;

    state_t             state;
    logic [N-1:0]       mask;
    logic [N-1:0]       pending;
    logic [N-1:0]       src_q;
    logic [TIMER_W-1:0] tcmp;
    logic [TIMER_W-1:0] tcnt;
    logic [ID_W-1:0]    irq_id_q;
    logic               irq_q;
    logic               busy_q;

    logic [TIMER_W-1:0] tcnt_next;
    logic               tmr_wrap;
    logic [N-1:0]       set_vec;
    logic [N-1:0]       clr_vec;
    logic [N-1:0]       pending_next;
    logic [N-1:0]       active;

    function automatic logic [ID_W-1:0] lowest_set(input logic [N-1:0] v);
        lowest_set = '0;
        for (int i = N - 1; i >= 0; i--)
            if (v[i]) lowest_set = ID_W'(i);
    endfunction

    // A TCNT write overrides both counting and the compare wrap in the same cycle.
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path infers a latch.
        tcnt_next = tcnt;
        tmr_wrap  = 1'b0;
        if (bus.wr_en && bus.wr_addr == A_TCNT) begin
            tcnt_next = bus.wr_data[TIMER_W-1:0];
        end else if (tcmp != '0) begin
            if (tcnt == tcmp) begin
                tcnt_next = '0;
                tmr_wrap  = 1'b1;
            end else begin
                tcnt_next = tcnt + 1'b1;
            end
        end
    end

    // Sets beat clears so an event coinciding with a W1C or ack is never lost.
    always_comb begin
        set_vec = (src_in & ~src_q & ~N'(1)) | N'(tmr_wrap);
        clr_vec = '0;
        if (bus.wr_en && bus.wr_addr == A_PEND)
            clr_vec = bus.wr_data[N-1:0];
        if (state == S_REQ && bus.irq_ack)
            clr_vec = clr_vec | (N'(1) << irq_id_q);
        pending_next = (pending & ~clr_vec) | set_vec;
        active       = pending & mask;
    end

    always_comb begin
        bus.rd_data = '0;
        case (bus.rd_addr)
            A_MASK:  bus.rd_data = 32'(mask);
            A_PEND:  bus.rd_data = 32'(pending);
            A_TCMP:  bus.rd_data = 32'(tcmp);
            default: bus.rd_data = 32'(tcnt);
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: no memories here, so every register is reset; <= makes all updates use pre-edge values.
        if (rst) begin
            state    <= S_IDLE;
            mask     <= '0;
            pending  <= '0;
            src_q    <= '0;
            tcmp     <= '0;
            tcnt     <= '0;
            irq_id_q <= '0;
            irq_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            src_q   <= src_in;
            pending <= pending_next;
            tcnt    <= tcnt_next;
            if (bus.wr_en && bus.wr_addr == A_MASK) mask <= bus.wr_data[N-1:0];
            if (bus.wr_en && bus.wr_addr == A_TCMP) tcmp <= bus.wr_data[TIMER_W-1:0];

            // Once raised, a request is held until CP0 acknowledges it.
            case (state)
                S_IDLE: if (active != '0) begin
                    irq_id_q <= lowest_set(active);
                    state    <= S_REQ;
                    irq_q    <= 1'b1;
                    busy_q   <= 1'b1;
                end
                S_REQ: if (bus.irq_ack) begin
                    state <= S_SERVICE;
                    irq_q <= 1'b0;
                end
                S_SERVICE: if (bus.irq_done) begin
                    state  <= S_IDLE;
                    busy_q <= 1'b0;
                end
                default: begin
                    state  <= S_IDLE;
                    irq_q  <= 1'b0;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.irq    = irq_q;
    assign bus.irq_id = irq_id_q;
    assign bus.busy   = busy_q;
endmodule

// File: tb/tb_irq_ctrl.sv
// Self-checking bench for irq_ctrl: register vector table plus hand-written
// sequences for priority, timer, no-withdraw and reset corner cases.
module tb_irq_ctrl;
    localparam int ID_W = 2;
    localparam int N    = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] src_in;

    irq_ctrl_if #(.ID_W(ID_W)) bus ();

    irq_ctrl #(.ID_W(ID_W), .TIMER_W(32)) dut (
        .clk   (clk),
        .rst   (rst),
        .src_in(src_in),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] val;
    } exp_t;

    typedef struct {
        logic        we;
        logic [1:0]  waddr;
        logic [31:0] wdata;
        logic [1:0]  raddr;
        logic [31:0] exp;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[9];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic sb_push(input string name, input logic [31:0] val);
        exp_t e;
        e.name = name;
        e.val  = val;
        sb.push_back(e);
    endtask

    task automatic sb_check(input logic [31:0] act);
        exp_t e;
        n_checks++;
        if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL scoreboard_empty actual=%h", act);
        end else begin
            e = sb.pop_front();
            if (act !== e.val) begin
                n_fail++;
                $display("FAIL %s actual=%h required=%h", e.name, act, e.val);
            end
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        sb_push(name, exp);
        sb_check(act);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] addr, input logic [31:0] data);
        bus.wr_en   = 1'b1;
        bus.wr_addr = addr;
        bus.wr_data = data;
        tick();
        bus.wr_en   = 1'b0;
    endtask

    task automatic rd(input logic [1:0] addr, output logic [31:0] data);
        bus.rd_addr = addr;
        #1;
        data = bus.rd_data;
    endtask

    task automatic check_reg(input string name, input logic [1:0] addr, input logic [31:0] exp);
        logic [31:0] d;
        rd(addr, d);
        check(name, d, exp);
    endtask

    task automatic pulse_ack();
        bus.irq_ack = 1'b1;
        tick();
        bus.irq_ack = 1'b0;
    endtask

    task automatic pulse_done();
        bus.irq_done = 1'b1;
        tick();
        bus.irq_done = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "bench did not finish");
    end

    initial begin
        logic [31:0] d;
        bit          seen;

        vecs[0] = '{1'b0, 2'd0, 32'h0,         2'd0, 32'h0};
        vecs[1] = '{1'b0, 2'd0, 32'h0,         2'd1, 32'h0};
        vecs[2] = '{1'b0, 2'd0, 32'h0,         2'd2, 32'h0};
        vecs[3] = '{1'b0, 2'd0, 32'h0,         2'd3, 32'h0};
        vecs[4] = '{1'b1, 2'd0, 32'hFFFF_FFF5, 2'd0, 32'h5};
        vecs[5] = '{1'b1, 2'd3, 32'h0000_1234, 2'd3, 32'h1234};
        vecs[6] = '{1'b0, 2'd0, 32'h0,         2'd3, 32'h1234};
        vecs[7] = '{1'b1, 2'd3, 32'h0,         2'd3, 32'h0};
        vecs[8] = '{1'b1, 2'd0, 32'h0,         2'd0, 32'h0};

        rst          = 1'b1;
        src_in       = '0;
        bus.wr_en    = 1'b0;
        bus.wr_addr  = '0;
        bus.wr_data  = '0;
        bus.rd_addr  = '0;
        bus.irq_ack  = 1'b0;
        bus.irq_done = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state and register read/write table.
        check("reset_irq", 32'(bus.irq), 32'd0);
        check("reset_busy", 32'(bus.busy), 32'd0);
        check("reset_irq_id", 32'(bus.irq_id), 32'd0);
        for (int i = 0; i < 9; i++) begin
            bus.wr_en   = vecs[i].we;
            bus.wr_addr = vecs[i].waddr;
            bus.wr_data = vecs[i].wdata;
            sb_push($sformatf("vec%0d", i), vecs[i].exp);
            tick();
            bus.wr_en = 1'b0;
            rd(vecs[i].raddr, d);
            sb_check(d);
        end

        // Masked-off edges latch into PENDING without requesting; bit 0 is not an external line.
        for (int b = 0; b < N; b++) begin
            src_in = N'(1) << b;
            tick();
            src_in = '0;
            tick();
        end
        check_reg("t1_pending", 2'd1, 32'hE);
        check("t1_irq", 32'(bus.irq), 32'd0);
        check("t1_busy", 32'(bus.busy), 32'd0);
        wr(2'd1, 32'hF);
        check_reg("t1_w1c", 2'd1, 32'h0);

        // Single source: two-edge latency, ack clears pending, done releases.
        wr(2'd0, 32'h4);
        src_in = 4'b0100;
        tick();
        check_reg("t2_pending", 2'd1, 32'h4);
        check("t2_irq_e0", 32'(bus.irq), 32'd0);
        tick();
        check("t2_irq_e1", 32'(bus.irq), 32'd1);
        check("t2_irq_id", 32'(bus.irq_id), 32'd2);
        check("t2_busy_req", 32'(bus.busy), 32'd1);
        pulse_ack();
        check("t2_irq_ack", 32'(bus.irq), 32'd0);
        check_reg("t2_pending_ack", 2'd1, 32'h0);
        check("t2_busy_svc", 32'(bus.busy), 32'd1);
        pulse_done();
        check("t2_busy_done", 32'(bus.busy), 32'd0);

        // Priority and back-to-back request one cycle after irq_done.
        src_in = '0;
        tick();
        wr(2'd0, 32'hF);
        src_in = 4'b1010;
        tick();
        tick();
        check("t3_irq", 32'(bus.irq), 32'd1);
        check("t3_irq_id", 32'(bus.irq_id), 32'd1);
        pulse_ack();
        pulse_done();
        check("t3_idle_after_done", 32'(bus.irq), 32'd0);
        tick();
        check("t3_irq2", 32'(bus.irq), 32'd1);
        check("t3_irq_id2", 32'(bus.irq_id), 32'd3);
        pulse_ack();
        pulse_done();
        check_reg("t3_pending_end", 2'd1, 32'h0);

        // Timer period with TCMP=5 and a TCNT write landing on a wrap cycle.
        src_in = '0;
        wr(2'd0, 32'h0);
        wr(2'd1, 32'hF);
        wr(2'd3, 32'h0);
        wr(2'd2, 32'h5);
        check_reg("t4_tcnt_start", 2'd3, 32'd0);
        for (int k = 1; k <= 5; k++) begin
            tick();
            check_reg($sformatf("t4_tcnt_%0d", k), 2'd3, 32'(k));
        end
        check_reg("t4_no_early_wrap", 2'd1, 32'h0);
        tick();
        check_reg("t4_tcnt_wrap", 2'd3, 32'd0);
        check_reg("t4_pending_wrap", 2'd1, 32'h1);
        wr(2'd1, 32'h1);
        check_reg("t4_tcnt_after_w1c", 2'd3, 32'd1);
        check_reg("t4_pending_w1c", 2'd1, 32'h0);
        for (int k = 0; k < 4; k++) tick();
        check_reg("t4_tcnt_at_cmp", 2'd3, 32'd5);
        wr(2'd3, 32'd2);
        check_reg("t4_tcnt_written", 2'd3, 32'd2);
        check_reg("t4_no_wrap_on_write", 2'd1, 32'h0);
        tick();
        check_reg("t4_tcnt_next", 2'd3, 32'd3);
        wr(2'd0, 32'h1);
        seen = 1'b0;
        for (int k = 0; k < 10 && !seen; k++) begin
            tick();
            if (bus.irq) seen = 1'b1;
        end
        check("t4_timer_irq_seen", 32'(seen), 32'd1);
        check("t4_timer_irq_id", 32'(bus.irq_id), 32'd0);
        pulse_ack();
        pulse_done();
        wr(2'd2, 32'h0);
        wr(2'd1, 32'hF);
        wr(2'd0, 32'h0);

        // No withdraw in REQ; an edge arriving in SERVICE is requested after return.
        wr(2'd0, 32'h2);
        src_in = 4'b0010;
        tick();
        tick();
        check("t5_irq", 32'(bus.irq), 32'd1);
        check("t5_irq_id", 32'(bus.irq_id), 32'd1);
        wr(2'd0, 32'h0);
        check("t5_hold_mask0", 32'(bus.irq), 32'd1);
        wr(2'd1, 32'hF);
        check("t5_hold_w1c", 32'(bus.irq), 32'd1);
        check_reg("t5_pending_w1c", 2'd1, 32'h0);
        pulse_ack();
        check("t5_irq_ack", 32'(bus.irq), 32'd0);
        check("t5_busy_svc", 32'(bus.busy), 32'd1);
        src_in = '0;
        tick();
        src_in = 4'b0010;
        tick();
        check_reg("t5_pending_in_svc", 2'd1, 32'h2);
        check("t5_irq_in_svc", 32'(bus.irq), 32'd0);
        pulse_ack();
        check("t5_ack_ignored_svc", 32'(bus.busy), 32'd1);
        check("t5_ack_ignored_irq", 32'(bus.irq), 32'd0);
        wr(2'd0, 32'h2);
        pulse_done();
        check("t5_busy_done", 32'(bus.busy), 32'd0);
        tick();
        check("t5_irq_after_done", 32'(bus.irq), 32'd1);
        check("t5_irq_id_after", 32'(bus.irq_id), 32'd1);
        pulse_ack();

        // Reset in SERVICE; stray ack/done in IDLE change nothing.
        check("t6_busy_before_rst", 32'(bus.busy), 32'd1);
        src_in = '0;
        rst    = 1'b1;
        tick();
        rst    = 1'b0;
        check("t6_irq", 32'(bus.irq), 32'd0);
        check("t6_busy", 32'(bus.busy), 32'd0);
        check_reg("t6_mask", 2'd0, 32'h0);
        check_reg("t6_pending", 2'd1, 32'h0);
        pulse_ack();
        check("t6_ack_idle", 32'(bus.busy), 32'd0);
        pulse_done();
        check("t6_done_idle_busy", 32'(bus.busy), 32'd0);
        check("t6_done_idle_irq", 32'(bus.irq), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
